// File: rtl/mmio_uart_tx.sv
// Memory-mapped transmit-only UART: CPU writes bytes into a TX FIFO and a serializer drains it as 8N1 frames.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] ADDR_BASE    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic        periph_hit,
    output logic [31:0] periph_rdata,
    output logic        uart_tx
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef MMIO_UART_PARITY_EN
    localparam logic            PAR_FLAG  = 1'b1;
`else
    localparam logic            PAR_FLAG  = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg;

    state_t           state_reg, state_next;
    logic [15:0]      baud_reg, baud_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
`ifdef MMIO_UART_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    logic             push_req, push_ok, pop, clr_ovf;
    logic             full, empty, busy, baud_done;
    logic [7:0]       head;
    logic [31:0]      status_word;
    logic             unused_bits;

    // Address decode; the low two address bits are don't-care.
    assign periph_hit = (dmem_addr[31:3] == ADDR_BASE[31:3]);
    assign push_req   = periph_hit & dmem_write & ~dmem_addr[2] & dmem_wmask[0];
    assign clr_ovf    = periph_hit & dmem_write & dmem_addr[2] & dmem_wmask[3] & dmem_wdata[31];
    assign unused_bits = ^{dmem_addr[1:0], dmem_wdata[30:8], dmem_wmask[2:1]};

    assign full      = (count_reg == DEPTH_C);
    assign empty     = (count_reg == '0);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok   = push_req & (~full | pop);
    assign head      = mem[rd_ptr_reg];
    assign baud_done = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= dmem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (!push_ok && pop) begin
                count_reg <= count_reg - CNT_ONE;
            end
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Serializer state register; uart_tx is driven from a flop so the line never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
`ifdef MMIO_UART_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        pop         = 1'b0;
`ifdef MMIO_UART_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
`ifdef MMIO_UART_PARITY_EN
                    parity_next = ^head;
`endif
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
`ifdef MMIO_UART_PARITY_EN
                        parity_next = ^head;
`endif
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_next = 1'b1;
        busy    = (state_reg != IDLE);
        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[0];
`ifdef MMIO_UART_PARITY_EN
            PARITY:  tx_next = parity_reg;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign uart_tx = tx_reg;

    assign status_word  = {16'h0000, 8'(count_reg), 3'b000, PAR_FLAG,
                           overflow_reg, busy, empty, full};
    assign periph_rdata = (periph_hit && dmem_addr[2]) ? status_word : 32'h0000_0000;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped transmit-only UART on the CPU data-memory bus, downstream of the cpu dmem port, alongside data memory.
- The CPU writes bytes into a TX FIFO. A serializer FSM drains the FIFO onto uart_tx as 8N1 frames.
- Status reads return combinationally in the same cycle, matching the single-cycle dmem contract.
- The top-level mux selects periph_rdata over memory read data when periph_hit=1.

Parameters:
- ADDR_BASE, 32'hFFFF_0000: word-aligned base address; block decodes ADDR_BASE+0x0 (TXDATA) and ADDR_BASE+0x4 (STATUS).
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  system clock. Clocking: one clock; reset is asynchronous and active-low.
- rst  in  1  asynchronous active-low reset.
- dmem_addr  in  32  CPU data address.
- dmem_write  in  1  CPU write strobe; each cycle it is high is one write.
- dmem_wmask  in  4  byte-lane enables.
- dmem_wdata  in  32  CPU write data.
- periph_hit  out  1  combinational: dmem_addr[31:3] matches ADDR_BASE[31:3].
- periph_rdata  out  32  combinational read data for the addressed register.
- uart_tx  out  1  serial output; idle high.

Behaviour:
- Reset (rst=0, async):
  - FIFO empty; count=0; overflow=0; FSM=IDLE.
  - uart_tx=1 asynchronously.
  - periph_rdata follows the decode with reset state values.
  - Reset mid-frame aborts the frame immediately; line goes high.
- Decode:
  - TXDATA when dmem_addr[2]=0; STATUS when dmem_addr[2]=1.
  - dmem_addr[1:0] ignored.
  - periph_rdata=0 when periph_hit=0.
- TXDATA write (hit, dmem_write=1, dmem_wmask[0]=1):
  - Pushes dmem_wdata[7:0] at the clock edge.
  - wmask[0]=0 means no push.
  - If full, the byte is dropped and overflow is set (sticky).
- TXDATA read returns 0. Reads have no side effects.
- STATUS read:
  - [0] full; [1] empty; [2] busy (FSM != IDLE); [3] overflow.
  - [15:8] FIFO count, zero-extended; all other bits 0.
- STATUS write with dmem_wmask[3]=1 and dmem_wdata[31]=1 clears overflow.
- Simultaneous push and pop in one cycle:
  - Count unchanged.
  - When full, a pop in the same cycle makes room, so the push succeeds with no overflow.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits, wrapping modulo depth. Count width is log2(FIFO_DEPTH)+1.
- FSM states: IDLE, START, DATA, STOP. Bit counter is 3 bits; baud counter is 16 bits.
  - IDLE: uart_tx=1. If FIFO non-empty, pop the head into the shift register and enter START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
  - DATA: uart_tx=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, enter STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE. If the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap).
- Latency: a push to an idle, empty block drives the start bit on uart_tx at the 2nd rising edge after the write edge (one cycle in IDLE for the pop).
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- uart_tx is registered (no glitches).

Optional Feature:
- Macro: MMIO_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles.
  - STATUS[4] reads 1.
- Undefined: 8N1 frames only; STATUS[4] reads 0.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset behaviour: assert rst=0 mid-frame after writing 0x55 -> uart_tx=1 immediately; STATUS reads 0x0000_0002 while reset is held and after release.
- Single byte: write 0xA5 to TXDATA (wmask=4'b0001) -> start bit low for 4 cycles at the 2nd edge after the write; then data 1,0,1,0,0,1,0,1 (4 cycles each); stop high 4 cycles; busy=0 after 40 cycles.
- Back-to-back: write 0x01,0x02,0x03 on consecutive cycles:
  - STATUS count reads 2 while the first frame is in progress.
  - Three frames with no idle gap.
  - Total 120 cycles from the first start bit.
- Overflow: while the first frame is on the line, write 6 bytes -> STATUS reads full=1, count=4, overflow=1. Then write STATUS 0x8000_0000 with wmask=4'b1000 -> overflow=0.
- Push during the full-to-pop edge: FIFO full, write on the exact cycle the FSM pops -> byte accepted, overflow stays 0, count stays 4.
- Decode and parity:
  - Write with wmask=4'b0010 to TXDATA -> no push.
  - Read ADDR_BASE+8 -> periph_hit=0, periph_rdata=0.
  - With MMIO_UART_PARITY_EN defined, 0x07 -> parity bit 1, frame 44 cycles.
